// File: rtl/common_def.sv
// Shared constants and types for the instruction-memory server.
package common_def;

  localparam int IMEM_ADDR_W  = 10;
  localparam int IMEM_INSTR_W = 12;

  localparam logic [IMEM_INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IMEM_HALT,
    IMEM_LOAD,
    IMEM_RUN
  } imem_state_t;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM: write-enable, registered read, no reset on contents.
module imem_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // One access per cycle: a write takes the port, otherwise an enabled read is registered.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory server: nibble-serial program loader, HALT/LOAD/RUN control FSM
// and the fetch read port with one-cycle latency.
// Optional feature macro: IMEM_PARITY_EN adds an even-parity bit per word; a read
// mismatch raises the sticky parity_err and drops the core back to HALT.
//
// Handshake: a nibble is transferred on a rising edge where ld_valid && ld_ready;
// ld_ready is high exactly while the FSM is in LOAD. ld_start overrides everything on
// its edge, so a nibble presented alongside it is discarded.
module imem_server
  import common_def::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int INSTR_W = IMEM_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               pc_enable,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [3:0]         ld_nibble,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               ld_overflow,
  output logic               parity_err
);

  localparam int NPW   = INSTR_W / 4;
  localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;
`ifdef IMEM_PARITY_EN
  localparam int RAM_W = INSTR_W + 1;
`else
  localparam int RAM_W = INSTR_W;
`endif

  imem_state_t        state;
  logic [ADDR_W-1:0]  ld_addr;
  logic [CNT_W-1:0]   nib_cnt;
  logic [INSTR_W-1:0] asm_q;
  logic               rd_valid;

  logic               accept;
  logic               word_end;
  logic               wr_en;
  logic               rd_en;
  logic [INSTR_W-1:0] shifted;
  logic [CNT_W-1:0]   fill_sh;
  logic [INSTR_W-1:0] wr_word;
  logic [ADDR_W-1:0]  ram_addr;
  logic [RAM_W-1:0]   ram_wdata;
  logic [RAM_W-1:0]   ram_rdata;
  logic               par_bad;

  // Load-side datapath: shift the new nibble in and left-justify a short final word.
  always_comb begin
    accept   = (state == IMEM_LOAD) && ld_valid && !ld_start;
    shifted  = {asm_q[INSTR_W-5:0], ld_nibble};
    word_end = (nib_cnt == CNT_W'(NPW - 1));
    wr_en    = accept && (word_end || ld_last);
    fill_sh  = CNT_W'(NPW - 1) - nib_cnt;
    wr_word  = shifted << {fill_sh, 2'b00};
    rd_en    = (state == IMEM_RUN);
    ram_addr = rd_en ? pc : ld_addr;
  end

`ifdef IMEM_PARITY_EN
  logic par_q;

  assign ram_wdata  = {^wr_word, wr_word};
  assign par_bad    = rd_valid && (^ram_rdata);
  assign parity_err = par_q;
`else
  assign ram_wdata  = wr_word;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // A corrupted word is never presented to fetch.
  assign instr_valid = rd_valid && !par_bad;
  assign instr       = instr_valid ? ram_rdata[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (RAM_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Control FSM with registered handshake/enable outputs and the load address/assembler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IMEM_HALT;
      ld_addr     <= '0;
      nib_cnt     <= '0;
      asm_q       <= '0;
      rd_valid    <= 1'b0;
      pc_enable   <= 1'b0;
      ld_ready    <= 1'b0;
      ld_overflow <= 1'b0;
`ifdef IMEM_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      rd_valid <= rd_en && !par_bad;
      if (ld_start) begin
        // Restart from address 0 in any state; any partially assembled word is lost.
        state     <= IMEM_LOAD;
        ld_addr   <= '0;
        nib_cnt   <= '0;
        asm_q     <= '0;
        ld_ready  <= 1'b1;
        pc_enable <= 1'b0;
`ifdef IMEM_PARITY_EN
        par_q     <= 1'b0;
`endif
      end else begin
        case (state)
          IMEM_HALT: begin
          end
          IMEM_LOAD: begin
            if (accept) begin
              if (wr_en) begin
                nib_cnt <= '0;
                asm_q   <= '0;
                ld_addr <= ld_addr + 1'b1;
                if (ld_addr == '1) begin
                  ld_overflow <= 1'b1;
                end
                if (ld_last) begin
                  state     <= IMEM_RUN;
                  ld_ready  <= 1'b0;
                  pc_enable <= 1'b1;
                end
              end else begin
                nib_cnt <= nib_cnt + 1'b1;
                asm_q   <= shifted;
              end
            end
          end
          IMEM_RUN: begin
            if (par_bad) begin
              state     <= IMEM_HALT;
              pc_enable <= 1'b0;
`ifdef IMEM_PARITY_EN
              par_q     <= 1'b1;
`endif
            end
          end
          default: begin
            state     <= IMEM_HALT;
            ld_ready  <= 1'b0;
            pc_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
